shift_sched: RTL and testbench

SHIFT_SCHED -- requirements
Module: shift_sched

---
 rtl/shift_sched.sv | 140 ++++++++++++++
 tb/tb_shift_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - two-requester scheduler in front of one shared external shifter
module shift_sched #(
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [OPERAND_WIDTH-1:0] req_in0,
  input  logic [OPERAND_WIDTH-1:0] req_in1,
  input  logic [SHAMT_WIDTH-1:0]   req_shamt0,
  input  logic [SHAMT_WIDTH-1:0]   req_shamt1,
  input  logic [1:0]               req_op0,
  input  logic [1:0]               req_op1,
  output logic [1:0]               rsp_valid,
  input  logic [1:0]               rsp_ready,
  output logic [OPERAND_WIDTH-1:0] rsp_data,
  output logic [OPERAND_WIDTH-1:0] sh_in,
  output logic [SHAMT_WIDTH-1:0]   sh_shamt,
  output logic [1:0]               sh_op,
  input  logic [OPERAND_WIDTH-1:0] sh_result,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     prio;
  logic                     owner;
  logic                     winner;
  logic                     accept;
  logic                     rsp_done;
  logic [OPERAND_WIDTH-1:0] lat_in;
  logic [SHAMT_WIDTH-1:0]   lat_shamt;
  logic [1:0]               lat_op;
  logic [OPERAND_WIDTH-1:0] win_in;
  logic [SHAMT_WIDTH-1:0]   win_shamt;
  logic [1:0]               win_op;

  // Arbitration: a lone requester wins outright; on contention the priority pointer decides.
  always_comb begin
    winner    = (req_valid == 2'b11) ? prio : req_valid[1];
    accept    = rst_n && (state == IDLE) && (req_valid != 2'b00);
    req_ready = 2'b00;
    if (accept) begin
      req_ready = winner ? 2'b10 : 2'b01;
    end
    win_in    = winner ? req_in1    : req_in0;
    win_shamt = winner ? req_shamt1 : req_shamt0;
    win_op    = winner ? req_op1    : req_op0;
    rsp_done  = (state == RESP) && rsp_ready[owner];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: zero shift amount bypasses the shifter and answers one cycle after acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (win_shamt == '0) ? RESP : SHIFT;
        end
      end
      SHIFT:   state_nxt = RESP;
      RESP: begin
        if (rsp_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted request so later input changes cannot disturb the operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_in    <= '0;
      lat_shamt <= '0;
      lat_op    <= 2'b00;
      owner     <= 1'b0;
    end else if (accept) begin
      lat_in    <= win_in;
      lat_shamt <= win_shamt;
      lat_op    <= win_op;
      owner     <= winner;
    end
  end

  // Result register: operand copied on bypass, shifter output captured at the end of SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
    end else if (accept && (win_shamt == '0)) begin
      rsp_data <= win_in;
    end else if (state == SHIFT) begin
      rsp_data <= sh_result;
    end
  end

  // Priority flips away from whoever was just served, so a persistent requester cannot starve the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (rsp_done) begin
      prio <= ~owner;
    end
  end

  // Output decode: shifter drive only during SHIFT, response strobe only toward the owner.
  always_comb begin
    sh_in     = '0;
    sh_shamt  = '0;
    sh_op     = 2'b00;
    rsp_valid = 2'b00;
    if (state == SHIFT) begin
      sh_in    = lat_in;
      sh_shamt = lat_shamt;
      sh_op    = lat_op;
    end
    if (state == RESP) begin
      rsp_valid = owner ? 2'b10 : 2'b01;
    end
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_shift_sched.sv
// tb/tb_shift_sched.sv - randomized self-checking bench for shift_sched with a behavioural model
module tb_shift_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_in0, req_in1;
  logic [3:0]  req_shamt0, req_shamt1;
  logic [1:0]  req_op0, req_op1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_data;
  logic [15:0] sh_in;
  logic [3:0]  sh_shamt;
  logic [1:0]  sh_op;
  logic [15:0] sh_result;
  logic        busy;

  int total = 0;
  int passed = 0;
  logic both_seen = 1'b0;

  shift_sched #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in0(req_in0), .req_in1(req_in1),
    .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sh_in(sh_in), .sh_shamt(sh_shamt), .sh_op(sh_op), .sh_result(sh_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // External shifter: 0=SLL, 1=SRL, 2=SRA, 3=ROR.
  function automatic logic [15:0] shf(input logic [15:0] a, input logic [3:0] s, input logic [1:0] o);
    logic [15:0] r;
    case (o)
      2'd0:    r = a << s;
      2'd1:    r = a >> s;
      2'd2:    r = $unsigned($signed(a) >>> s);
      default: r = (s == 4'd0) ? a : ((a >> s) | (a << (16 - int'(s))));
    endcase
    return r;
  endfunction

  always_comb sh_result = shf(sh_in, sh_shamt, sh_op);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  // Drives one request, drops valids and scrambles operands after acceptance, waits for the response.
  task automatic issue(input logic [1:0] v,
                       input logic [15:0] a0, input logic [3:0] s0, input logic [1:0] o0,
                       input logic [15:0] a1, input logic [3:0] s1, input logic [1:0] o1,
                       output int gnt, output int lat, output logic [15:0] data,
                       output logic [1:0] rv, output logic [15:0] sh_or);
    int n;
    gnt = -1; lat = -1; data = 16'h0; rv = 2'b00; sh_or = 16'h0;
    req_valid = v;
    req_in0 = a0; req_shamt0 = s0; req_op0 = o0;
    req_in1 = a1; req_shamt1 = s1; req_op1 = o1;
    n = 0;
    @(negedge clk);
    sh_or = sh_or | sh_in;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == 2'b11) both_seen = 1'b1;
    if (req_ready == 2'b00) begin
      req_valid = 2'b00;
      return;
    end
    gnt = req_ready[1] ? 1 : 0;
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_in0 = 16'($urandom); req_shamt0 = 4'($urandom); req_op0 = 2'($urandom);
    req_in1 = 16'($urandom); req_shamt1 = 4'($urandom); req_op1 = 2'($urandom);
    n = 1;
    @(negedge clk);
    sh_or = sh_or | sh_in;
    while (rsp_valid == 2'b00 && n < 20) begin
      @(negedge clk);
      sh_or = sh_or | sh_in;
      n++;
    end
    if (rsp_valid == 2'b00) return;
    lat = n; data = rsp_data; rv = rsp_valid;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b11;
    req_in0 = 16'h1111; req_in1 = 16'h2222; req_shamt0 = 4'd1; req_shamt1 = 4'd2;
    req_op0 = 2'd0; req_op1 = 2'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready); else passed++;
    total++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); else passed++;
    total++; if (rsp_data !== 16'h0) $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (sh_in !== 16'h0) $display("FAIL reset_sh_in: got %h want 0000", sh_in); else passed++;
    req_valid = 2'b00;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_shift();
    req_valid = 2'b01; req_in0 = 16'h8001; req_shamt0 = 4'd1; req_op0 = 2'd1; rsp_ready = 2'b11;
    @(negedge clk);
    total++; if (req_ready !== 2'b01) $display("FAIL single_ready_t0: got %b want 01", req_ready); else passed++;
    total++; if (sh_in !== 16'h0) $display("FAIL single_sh_in_t0: got %h want 0000", sh_in); else passed++;
    @(posedge clk); #1;
    req_valid = 2'b00; req_in0 = 16'h0;
    @(negedge clk);
    total++; if (sh_in !== 16'h8001 || sh_shamt !== 4'd1 || sh_op !== 2'd1)
      $display("FAIL single_sh_drive_t1: got %h/%0d/%0d want 8001/1/1", sh_in, sh_shamt, sh_op); else passed++;
    total++; if (rsp_valid !== 2'b00) $display("FAIL single_no_rsp_t1: got %b want 00", rsp_valid); else passed++;
    @(negedge clk);
    total++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h4000)
      $display("FAIL single_rsp_t2: got %b/%h want 01/4000", rsp_valid, rsp_data); else passed++;
    total++; if (sh_in !== 16'h0) $display("FAIL single_sh_in_t2: got %h want 0000", sh_in); else passed++;
    @(negedge clk);
    total++; if (rsp_valid !== 2'b00 || busy !== 1'b0)
      $display("FAIL single_done: got rsp_valid=%b busy=%b want 00/0", rsp_valid, busy); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int g, l; logic [15:0] d, so; logic [1:0] rv;
    rst_n = 1'b0; #2 rst_n = 1'b1;
    @(posedge clk); #1;
    both_seen = 1'b0; rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      issue(2'b11, 16'h0101, 4'd1, 2'd0, 16'h0202, 4'd2, 2'd0, g, l, d, rv, so);
      total++; if (g !== (i % 2)) $display("FAIL contention_grant_%0d: got %0d want %0d", i, g, i % 2); else passed++;
    end
    total++; if (both_seen !== 1'b0) $display("FAIL contention_ready_11: got %b want 0", both_seen); else passed++;
  endtask

  task automatic test_bypass();
    int g, l; logic [15:0] d, so; logic [1:0] rv;
    rsp_ready = 2'b11;
    issue(2'b01, 16'hBEEF, 4'd0, 2'd2, 16'h0, 4'd0, 2'd0, g, l, d, rv, so);
    total++; if (l !== 1) $display("FAIL bypass_latency: got %0d want 1", l); else passed++;
    total++; if (d !== 16'hBEEF || rv !== 2'b01) $display("FAIL bypass_data: got %h/%b want beef/01", d, rv); else passed++;
    total++; if (so !== 16'h0) $display("FAIL bypass_sh_in: got %h want 0000", so); else passed++;
  endtask

  task automatic test_backpressure();
    int n;
    req_valid = 2'b01; req_in0 = 16'h1234; req_shamt0 = 4'd3; req_op0 = 2'd0; rsp_ready = 2'b10;
    @(negedge clk);
    total++; if (req_ready !== 2'b01) $display("FAIL bp_ready: got %b want 01", req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 2'b10; req_in1 = 16'h5555; req_shamt1 = 4'd0; req_op1 = 2'd0; req_in0 = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    total++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h91A0)
      $display("FAIL bp_first_rsp: got %b/%h want 01/91a0", rsp_valid, rsp_data); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h91A0 || req_ready !== 2'b00)
        $display("FAIL bp_hold_%0d: got rsp_valid=%b data=%h req_ready=%b want 01/91a0/00", i, rsp_valid, rsp_data, req_ready);
      else passed++;
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    total++; if (rsp_valid !== 2'b01) $display("FAIL bp_release_cycle: got %b want 01", rsp_valid); else passed++;
    @(negedge clk);
    total++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10)
      $display("FAIL bp_complete: got rsp_valid=%b req_ready=%b want 00/10", rsp_valid, req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 2'b00;
    n = 0;
    @(negedge clk);
    while (busy && n < 10) begin @(negedge clk); n++; end
    total++; if (busy !== 1'b0) $display("FAIL bp_drain: got busy=%b want 0", busy); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_operand_change();
    int g, l; logic [15:0] d, so; logic [1:0] rv;
    rsp_ready = 2'b11;
    issue(2'b10, 16'h0, 4'd0, 2'd0, 16'h00F0, 4'd4, 2'd0, g, l, d, rv, so);
    total++; if (d !== 16'h0F00 || l !== 2 || rv !== 2'b10)
      $display("FAIL operand_latched: got %h lat=%0d rv=%b want 0f00/2/10", d, l, rv); else passed++;
  endtask

  task automatic test_reset_mid();
    int g, l, n; logic [15:0] d, so; logic [1:0] rv; logic seen;
    rsp_ready = 2'b11;
    issue(2'b01, 16'h0003, 4'd1, 2'd0, 16'h0, 4'd0, 2'd0, g, l, d, rv, so);
    req_valid = 2'b01; req_in0 = 16'hAAAA; req_shamt0 = 4'd2; req_op0 = 2'd1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    total++; if (sh_in !== 16'hAAAA || busy !== 1'b1) $display("FAIL rmid_in_shift: got sh_in=%h busy=%b want aaaa/1", sh_in, busy); else passed++;
    #1 rst_n = 1'b0; req_valid = 2'b11;
    #1;
    total++; if (rsp_valid !== 2'b00 || rsp_data !== 16'h0 || sh_in !== 16'h0 || sh_shamt !== 4'd0 || sh_op !== 2'd0)
      $display("FAIL rmid_async_clear: got rv=%b data=%h sh=%h/%0d/%0d want all 0", rsp_valid, rsp_data, sh_in, sh_shamt, sh_op);
    else passed++;
    total++; if (busy !== 1'b0 || req_ready !== 2'b00) $display("FAIL rmid_async_ctrl: got busy=%b ready=%b want 0/00", busy, req_ready); else passed++;
    @(posedge clk);
    @(negedge clk); #1;
    req_valid = 2'b00; rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL rmid_no_result: got activity=%b want 0", seen); else passed++;
    @(posedge clk); #1;
    issue(2'b11, 16'h0001, 4'd1, 2'd0, 16'h0002, 4'd1, 2'd0, g, l, d, rv, so);
    total++; if (g !== 0) $display("FAIL rmid_first_grant: got %0d want 0", g); else passed++;
  endtask

  task automatic test_random();
    int g, l, exp_g, exp_l, n;
    logic [15:0] d, so, a0, a1, exp_d;
    logic [3:0] s0, s1; logic [1:0] o0, o1, v, rv;
    logic mprio;
    rst_n = 1'b0; #2 rst_n = 1'b1;
    @(posedge clk); #1;
    mprio = 1'b0; rsp_ready = 2'b11;
    for (int i = 0; i < 30; i++) begin
      v = 2'($urandom_range(1, 3));
      a0 = 16'($urandom); a1 = 16'($urandom);
      s0 = (($urandom % 4) == 0) ? 4'd0 : 4'($urandom);
      s1 = (($urandom % 4) == 0) ? 4'd0 : 4'($urandom);
      o0 = 2'($urandom); o1 = 2'($urandom);
      if (v == 2'b11) exp_g = int'(mprio);
      else exp_g = v[1] ? 1 : 0;
      if (exp_g == 0) begin
        exp_d = (s0 == 0) ? a0 : shf(a0, s0, o0);
        exp_l = (s0 == 0) ? 1 : 2;
      end else begin
        exp_d = (s1 == 0) ? a1 : shf(a1, s1, o1);
        exp_l = (s1 == 0) ? 1 : 2;
      end
      mprio = (exp_g == 0);
      n = int'($urandom_range(0, 2));
      repeat (n) begin @(posedge clk); #1; end
      issue(v, a0, s0, o0, a1, s1, o1, g, l, d, rv, so);
      total++; if (g !== exp_g) $display("FAIL rand_grant_%0d: got %0d want %0d", i, g, exp_g); else passed++;
      total++; if (l !== exp_l) $display("FAIL rand_latency_%0d: got %0d want %0d", i, l, exp_l); else passed++;
      total++; if (d !== exp_d) $display("FAIL rand_data_%0d: got %h want %h", i, d, exp_d); else passed++;
      total++; if (rv !== (exp_g == 1 ? 2'b10 : 2'b01)) $display("FAIL rand_rsp_valid_%0d: got %b want onehot %0d", i, rv, exp_g); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_shift();
    test_contention();
    test_bypass();
    test_backpressure();
    test_operand_change();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
